// File: rtl/mem_port_if.sv
// Request/response bundle between the core's fetch and load/store ports, the arbiter and the shared memory.
// master: core requesters plus the memory's read-data return. slave: the arbiter.
interface mem_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (IF) and load/store (D) ports onto one fixed-latency single-port memory.
// Optional macro ARB_PERF_CNT_EN adds grant/conflict performance counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  mem_port_if.slave   bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_if_gnts,
  output logic [31:0] o_perf_d_gnts,
  output logic [31:0] o_perf_conflicts
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] LAT_LOAD  = 4'(MEM_LAT - 1);
  localparam logic [7:0] STARVE_TH = 8'(STARVE_MAX);

  state_t      r_state;
  logic [3:0]  r_lat_cnt;
  logic [7:0]  r_starve_cnt;

  logic              w_done;
  logic              w_can_issue;
  logic              w_if_wins;
  logic              w_if_gnt;
  logic              w_d_gnt;
  logic              w_if_done;
  logic              w_d_done;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  // The completion cycle doubles as an issue slot so reads can run back-to-back.
  assign w_done      = (r_state != IDLE) && (r_lat_cnt == 4'd0);
  assign w_can_issue = !i_rst && ((r_state == IDLE) || w_done);
  assign w_if_wins   = bus.if_req && (!bus.d_req || (r_starve_cnt >= STARVE_TH));
  assign w_if_gnt    = w_can_issue && w_if_wins;
  assign w_d_gnt     = w_can_issue && bus.d_req && !w_if_wins;
  assign w_if_done   = !i_rst && w_done && (r_state == BUSY_I);
  assign w_d_done    = !i_rst && w_done && (r_state == BUSY_D);

  assign w_mem_addr  = w_if_gnt ? bus.if_addr : (w_d_gnt ? bus.d_addr : '0);
  assign w_mem_wdata = w_d_gnt ? bus.d_wdata : '0;

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.mem_req   = w_if_gnt || w_d_gnt;
  assign bus.mem_wen   = w_d_gnt && bus.d_wen;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.if_rvalid = w_if_done;
  assign bus.if_rdata  = w_if_done ? bus.mem_rdata : '0;
  assign bus.d_rvalid  = w_d_done;
  assign bus.d_rdata   = w_d_done ? bus.mem_rdata : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (w_if_gnt) begin
        r_state   <= BUSY_I;
        r_lat_cnt <= LAT_LOAD;
      end else if (w_d_gnt && !bus.d_wen) begin
        r_state   <= BUSY_D;
        r_lat_cnt <= LAT_LOAD;
      end else if (w_d_gnt || w_done) begin
        // Stores commit at issue and free the port after one cycle.
        r_state <= IDLE;
      end else if (r_state != IDLE) begin
        r_lat_cnt <= r_lat_cnt - 4'd1;
      end

      if (w_if_gnt) begin
        r_starve_cnt <= '0;
      end else if (bus.if_req && (r_starve_cnt != 8'hFF)) begin
        r_starve_cnt <= r_starve_cnt + 8'd1;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_perf_if_gnts   <= '0;
      o_perf_d_gnts    <= '0;
      o_perf_conflicts <= '0;
    end else begin
      if (w_if_gnt) o_perf_if_gnts <= o_perf_if_gnts + 32'd1;
      if (w_d_gnt)  o_perf_d_gnts  <= o_perf_d_gnts + 32'd1;
      if (bus.if_req && bus.d_req && (w_if_gnt || w_d_gnt))
        o_perf_conflicts <= o_perf_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 2, 1, 3) share one directed stimulus stream;
// each has its own memory model and a timeline-based reference model checked every cycle.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_if_req;
  logic [31:0] s_if_addr;
  logic        s_d_req;
  logic        s_d_wen;
  logic [31:0] s_d_addr;
  logic [31:0] s_d_wdata;

  int checks   = 0;
  int failures = 0;

  logic        o_if_gnt [3];
  logic        o_if_rv  [3];
  logic [31:0] o_if_rd  [3];
  logic        o_d_gnt  [3];
  logic        o_d_rv   [3];
  logic [31:0] o_d_rd   [3];
  logic        o_mreq   [3];
  logic        o_mwen   [3];
  logic [31:0] o_maddr  [3];
  logic [31:0] o_mwdata [3];
`ifdef ARB_PERF_CNT_EN
  logic [31:0] o_pf_if [3];
  logic [31:0] o_pf_d  [3];
  logic [31:0] o_pf_cf [3];
`endif

  typedef struct {
    int          due;
    bit          is_d;
    logic [31:0] data;
  } pend_t;

  task automatic cmp1(input string nm, input int inst, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%0b expected=%0b t=%0t", nm, inst, act, exp, $time);
    end
  endtask

  task automatic cmp32(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%h expected=%h t=%0t", nm, inst, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 3);

    mem_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    logic [31:0] r_mem_rdata = '0;
    logic [31:0] r_next = '0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(4)) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
`ifdef ARB_PERF_CNT_EN
      ,
      .o_perf_if_gnts   (o_pf_if[g]),
      .o_perf_d_gnts    (o_pf_d[g]),
      .o_perf_conflicts (o_pf_cf[g])
`endif
    );

    assign bus.if_req    = s_if_req;
    assign bus.if_addr   = s_if_addr;
    assign bus.d_req     = s_d_req;
    assign bus.d_wen     = s_d_wen;
    assign bus.d_addr    = s_d_addr;
    assign bus.d_wdata   = s_d_wdata;
    assign bus.mem_rdata = r_mem_rdata;

    assign o_if_gnt[g] = bus.if_gnt;
    assign o_if_rv[g]  = bus.if_rvalid;
    assign o_if_rd[g]  = bus.if_rdata;
    assign o_d_gnt[g]  = bus.d_gnt;
    assign o_d_rv[g]   = bus.d_rvalid;
    assign o_d_rd[g]   = bus.d_rdata;
    assign o_mreq[g]   = bus.mem_req;
    assign o_mwen[g]   = bus.mem_wen;
    assign o_maddr[g]  = bus.mem_addr;
    assign o_mwdata[g] = bus.mem_wdata;

    // Memory contents: written words, else a fixed address-derived pattern.
    logic [31:0] mem [logic [31:0]];
    pend_t pend[$];
    pend_t mret[$];
    int cyc     = 0;
    int free_at = 0;
    int starve  = 0;
    logic e_ig, e_dg, e_irv, e_drv, e_wen;
    logic [31:0] e_ird, e_drd, e_addr, e_wd, rdv;
    bit can_issue, if_wins;

    initial mem[32'h100] = 32'hDEADBEEF;

    always @(posedge clk) r_mem_rdata <= r_next;

    always @(negedge clk) begin
      e_ig = 0; e_dg = 0; e_irv = 0; e_drv = 0; e_wen = 0;
      e_ird = '0; e_drd = '0; e_addr = '0; e_wd = '0;
      if (!rst) begin
        e_irv     = (pend.size() > 0) && (pend[0].due == cyc) && !pend[0].is_d;
        e_drv     = (pend.size() > 0) && (pend[0].due == cyc) && pend[0].is_d;
        e_ird     = e_irv ? pend[0].data : '0;
        e_drd     = e_drv ? pend[0].data : '0;
        can_issue = (cyc >= free_at);
        if_wins   = s_if_req && (!s_d_req || (starve >= 4));
        e_ig      = can_issue && if_wins;
        e_dg      = can_issue && s_d_req && !if_wins;
        e_wen     = e_dg && s_d_wen;
        e_addr    = e_ig ? s_if_addr : (e_dg ? s_d_addr : '0);
        e_wd      = e_dg ? s_d_wdata : '0;
      end
      cmp1 ("m_if_gnt",    g, bus.if_gnt,    e_ig);
      cmp1 ("m_d_gnt",     g, bus.d_gnt,     e_dg);
      cmp1 ("m_mem_req",   g, bus.mem_req,   e_ig || e_dg);
      cmp1 ("m_mem_wen",   g, bus.mem_wen,   e_wen);
      cmp32("m_mem_addr",  g, bus.mem_addr,  e_addr);
      cmp32("m_mem_wdata", g, bus.mem_wdata, e_wd);
      cmp1 ("m_if_rvalid", g, bus.if_rvalid, e_irv);
      cmp32("m_if_rdata",  g, bus.if_rdata,  e_ird);
      cmp1 ("m_d_rvalid",  g, bus.d_rvalid,  e_drv);
      cmp32("m_d_rdata",   g, bus.d_rdata,   e_drd);

      if (rst) begin
        pend.delete();
        free_at = cyc + 1;
        starve  = 0;
      end else begin
        if ((pend.size() > 0) && (pend[0].due == cyc)) void'(pend.pop_front());
        if (e_ig) begin
          rdv = mem.exists(s_if_addr) ? mem[s_if_addr] : (s_if_addr ^ 32'h5A5A_0000);
          pend.push_back('{cyc + LAT, 1'b0, rdv});
          free_at = cyc + LAT;
        end else if (e_dg) begin
          if (s_d_wen) begin
            free_at = cyc + 1;
          end else begin
            rdv = mem.exists(s_d_addr) ? mem[s_d_addr] : (s_d_addr ^ 32'h5A5A_0000);
            pend.push_back('{cyc + LAT, 1'b1, rdv});
            free_at = cyc + LAT;
          end
        end
        if (e_ig) starve = 0;
        else if (s_if_req && (starve < 255)) starve++;
      end

      // Memory side: acts on what the arbiter actually drove; returns data exactly LAT cycles later.
      if (bus.mem_req) begin
        if (bus.mem_wen) begin
          mem[bus.mem_addr] = bus.mem_wdata;
        end else begin
          rdv = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : (bus.mem_addr ^ 32'h5A5A_0000);
          mret.push_back('{cyc + LAT, 1'b0, rdv});
        end
      end
      if ((mret.size() > 0) && (mret[0].due == cyc + 1)) begin
        r_next = mret[0].data;
        void'(mret.pop_front());
      end else begin
        r_next = 32'hBAD0_0000 + 32'(cyc);
      end
      cyc++;
    end
  end

  task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    rst = r; s_if_req = ir; s_if_addr = ia;
    s_d_req = dr; s_d_wen = dw; s_d_addr = da; s_d_wdata = dd;
  endtask

  task automatic at_neg;
    @(negedge clk);
    #1;
  endtask

`ifdef ARB_PERF_CNT_EN
  logic [31:0] snap_if, snap_d, snap_cf;
`endif

  initial begin
    rst = 1'b0; s_if_req = 1'b0; s_if_addr = '0;
    s_d_req = 1'b0; s_d_wen = 1'b0; s_d_addr = '0; s_d_wdata = '0;
    #1;
    rst = 1'b1; s_if_req = 1'b1; s_if_addr = 32'h100;
    at_neg;
    cmp1 ("rst_if_gnt",   0, o_if_gnt[0], 1'b0);
    cmp1 ("rst_mem_req",  0, o_mreq[0],   1'b0);
    cmp32("rst_mem_addr", 0, o_maddr[0],  32'h0);

    // IF-only read of 0x100.
    step(0, 1, 32'h100, 0, 0, 0, 0); at_neg;
    cmp1 ("if_gnt_c0",   0, o_if_gnt[0], 1'b1);
    cmp32("if_addr_c0",  0, o_maddr[0],  32'h100);
    cmp1 ("if_dgnt_c0",  0, o_d_gnt[0],  1'b0);
    step(0, 0, 0, 0, 0, 0, 0); at_neg;
    cmp1 ("if_rv_c1",    0, o_if_rv[0],  1'b0);
    cmp1 ("lat1_rv_c1",  1, o_if_rv[1],  1'b1);
    cmp32("lat1_rd_c1",  1, o_if_rd[1],  32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0, 0); at_neg;
    cmp1 ("if_rv_c2",    0, o_if_rv[0],  1'b1);
    cmp32("if_rd_c2",    0, o_if_rd[0],  32'hDEADBEEF);
    cmp1 ("if_drv_c2",   0, o_d_rv[0],   1'b0);
    cmp32("if_drd_c2",   0, o_d_rd[0],   32'h0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);

    // Conflict: D wins, IF granted in D's completion cycle.
    step(0, 1, 32'h104, 1, 0, 32'h200, 0); at_neg;
`ifdef ARB_PERF_CNT_EN
    snap_if = o_pf_if[0]; snap_d = o_pf_d[0]; snap_cf = o_pf_cf[0];
`endif
    cmp1 ("cf_dgnt_c0",  0, o_d_gnt[0],  1'b1);
    cmp1 ("cf_ifgnt_c0", 0, o_if_gnt[0], 1'b0);
    cmp32("cf_addr_c0",  0, o_maddr[0],  32'h200);
    step(0, 1, 32'h104, 0, 0, 0, 0); at_neg;
    cmp1 ("cf_ifgnt_c1", 0, o_if_gnt[0], 1'b0);
    step(0, 1, 32'h104, 0, 0, 0, 0); at_neg;
    cmp1 ("cf_drv_c2",   0, o_d_rv[0],   1'b1);
    cmp32("cf_drd_c2",   0, o_d_rd[0],   32'h5A5A_0200);
    cmp1 ("cf_ifgnt_c2", 0, o_if_gnt[0], 1'b1);
    step(0, 0, 0, 0, 0, 0, 0); at_neg;
`ifdef ARB_PERF_CNT_EN
    cmp32("perf_conflicts", 0, o_pf_cf[0] - snap_cf, 32'd1);
    cmp32("perf_d_gnts",    0, o_pf_d[0] - snap_d,   32'd1);
    cmp32("perf_if_gnts",   0, o_pf_if[0] - snap_if, 32'd1);
`endif
    repeat (5) step(0, 0, 0, 0, 0, 0, 0);

    // Starvation with MEM_LAT=1: four D issues, then IF forced, counter restarts.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 32'h180, 1, 0, 32'h220, 0); at_neg;
      cmp1("stv_dgnt",  1, o_d_gnt[1],  (i != 4) && (i != 9));
      cmp1("stv_ifgnt", 1, o_if_gnt[1], (i == 4) || (i == 9));
    end
    repeat (6) step(0, 0, 0, 0, 0, 0, 0);

    // Store stream, one per cycle.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 1, 32'h10 + 32'(4 * i), 32'h1111_0000 + 32'(i)); at_neg;
      cmp1 ("st_dgnt",  0, o_d_gnt[0],  1'b1);
      cmp1 ("st_wen",   0, o_mwen[0],   1'b1);
      cmp32("st_addr",  0, o_maddr[0],  32'h10 + 32'(4 * i));
      cmp32("st_wdata", 0, o_mwdata[0], 32'h1111_0000 + 32'(i));
      cmp1 ("st_drv",   0, o_d_rv[0],   1'b0);
    end
    step(0, 0, 0, 1, 0, 32'h14, 0); at_neg;
    cmp1 ("ld_dgnt", 1, o_d_gnt[1], 1'b1);
    step(0, 0, 0, 0, 0, 0, 0); at_neg;
    cmp1 ("ld_drv",  1, o_d_rv[1],  1'b1);
    cmp32("ld_drd",  1, o_d_rd[1],  32'h1111_0001);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);

    // Reset during an outstanding MEM_LAT=3 fetch.
    step(0, 1, 32'h300, 0, 0, 0, 0); at_neg;
    cmp1 ("rm_ifgnt_c0", 2, o_if_gnt[2], 1'b1);
    step(1, 1, 32'h300, 0, 0, 0, 0); at_neg;
    cmp1 ("rm_ifgnt_r",  2, o_if_gnt[2], 1'b0);
    cmp1 ("rm_mreq_r",   2, o_mreq[2],   1'b0);
    cmp32("rm_maddr_r",  2, o_maddr[2],  32'h0);
    step(1, 1, 32'h300, 0, 0, 0, 0); at_neg;
    cmp1 ("rm_ifrv_r",   2, o_if_rv[2],  1'b0);
    step(0, 1, 32'h304, 0, 0, 0, 0); at_neg;
    cmp1 ("rm_ifgnt_rel", 2, o_if_gnt[2], 1'b1);
    cmp1 ("rm_ifrv_rel",  2, o_if_rv[2],  1'b0);
    cmp32("rm_maddr_rel", 2, o_maddr[2],  32'h304);
    step(0, 0, 0, 0, 0, 0, 0); at_neg;
    cmp1 ("rm_ifrv_p1",  2, o_if_rv[2],  1'b0);
    step(0, 0, 0, 0, 0, 0, 0); at_neg;
    cmp1 ("rm_ifrv_p2",  2, o_if_rv[2],  1'b0);
    step(0, 0, 0, 0, 0, 0, 0); at_neg;
    cmp1 ("rm_ifrv_p3",  2, o_if_rv[2],  1'b1);
    cmp32("rm_ifrd_p3",  2, o_if_rd[2],  32'h5A5A_0304);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    at_neg;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one fixed-latency, single-port unified memory between the fetch stage (IF requester) and the load/store stage (D requester) of the 5-stage pipeline core.
- Decides which requester owns the port each cycle, sequences each access through a latency counter, and returns read data to the owner.
- Fetch starvation is bounded by a counter.
- Sits between the core's imem/dmem interfaces and the shared memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from issue to read data valid; legal range 1..15.
- STARVE_MAX, 4, consecutive cycles a pending IF request may lose before it is forced to win; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held stable until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  if_rdata valid this cycle.
- if_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request; held stable until d_gnt.
- d_wen  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  d_rdata valid (loads only).
- d_rdata  out  DATA_W  load data.
- mem_req  out  1  issue strobe to memory.
- mem_wen  out  1  write enable to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid exactly MEM_LAT cycles after the mem_req cycle.

Behaviour:
- State machine: IDLE, BUSY_I, BUSY_D. Latency counter lat_cnt is 4 bits. Starvation counter starve_cnt is 8 bits and saturates.
- Reset (asynchronous, while rst = 1):
  - state = IDLE, lat_cnt = 0, starve_cnt = 0.
  - All outputs are forced to 0: gnt, rvalid, mem_req, mem_wen, mem_addr, mem_wdata, if_rdata, d_rdata.
- Issue: allowed in IDLE, or in the completion cycle of BUSY_x (back-to-back issue).
  - Winner when only one request is present: that requester.
  - Winner when both are present: D, unless starve_cnt >= STARVE_MAX, in which case IF wins.
  - Winner's gnt = 1, mem_req = 1, and mem_addr/mem_wen/mem_wdata are driven combinationally from the winner in the same cycle.
  - Loser's gnt = 0. With no issue, mem_req = 0 and mem_addr/mem_wdata/mem_wen = 0.
- Load or fetch issue: next state is BUSY_I or BUSY_D, lat_cnt <= MEM_LAT-1.
  - In BUSY_x, lat_cnt decrements each cycle.
  - Completion cycle is lat_cnt == 0 in BUSY_x: that requester's rvalid = 1 and rdata = mem_rdata (combinational pass-through).
  - Next state after completion is IDLE, or a new BUSY_x if an issue happens in that cycle.
- Store issue: write is committed at issue. Next state is IDLE, so the port is occupied one cycle. No d_rvalid is produced.
- rdata outputs are 0 whenever rvalid = 0.
- Outside the completion cycle, no gnt is given while in BUSY_x, so requests stall.
- starve_cnt:
  - Increments (saturating at 255) each cycle if_req = 1 and if_gnt = 0.
  - Clears on if_gnt.
  - Unchanged when if_req = 0.
- Latency: load/fetch data appears MEM_LAT cycles after gnt. Throughput is one access per MEM_LAT cycles for reads and one per cycle for stores.
- Boundary conditions:
  - MEM_LAT = 1: lat_cnt loads 0, completion is the next cycle, and back-to-back issue gives one access per cycle.
  - Simultaneous completion and new request from the same requester: rvalid and gnt are both 1 in the same cycle.
  - Requester drops req without a gnt: legal, no state change.
  - Reset asserted mid-access: outstanding access is discarded, no rvalid after reset release, and starve_cnt = 0.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined, adds three output ports, each 32-bit, wrapping, reset to 0:
  - perf_if_gnts: count of if_gnt cycles.
  - perf_d_gnts: count of d_gnt cycles.
  - perf_conflicts: count of cycles where if_req and d_req are both 1 and an issue occurs.
- When undefined, these ports and their registers do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Reset then IF-only read: if_req=1, if_addr=0x100, MEM_LAT=2, memory returns 0xDEADBEEF -> if_gnt in cycle 0, mem_addr=0x100, if_rvalid=1 and if_rdata=0xDEADBEEF in cycle 2, d_* outputs remain 0.
- Conflict with data priority: if_req and d_req (load at 0x200) both asserted in IDLE -> d_gnt=1, if_gnt=0; at D completion if_gnt=1 in the same cycle d_rvalid=1.
- Starvation: STARVE_MAX=4, MEM_LAT=1, d_req held 1 continuously with if_req=1 -> D wins 4 consecutive issues, 5th issue goes to IF (if_gnt=1), then starve_cnt returns to 0.
- Store stream: d_req=1, d_wen=1, addresses 0x10, 0x14, 0x18 on consecutive cycles -> d_gnt=1 each cycle, mem_wen=1 with matching mem_addr/mem_wdata, d_rvalid never asserted.
- Reset mid-access: issue an IF read with MEM_LAT=3, assert rst one cycle later for 2 cycles -> all outputs 0 during reset, no if_rvalid after release, next if_req is granted immediately.
- ARB_PERF_CNT_EN defined: run the conflict test -> perf_conflicts=1, perf_d_gnts=1, perf_if_gnts=1.
